// File: rtl/oled_seq.sv
// rtl/oled_seq.sv - OLED panel power-up/power-down sequencer with SPI command output
// Optional power-down sequence on stop: define OLED_SEQ_PWRDOWN_EN.
`timescale 1ns/1ps

module oled_seq #(
  parameter int          CLK_DIV       = 4,
  parameter int          MS_CYCLES     = 100000,
  parameter int          VBAT_DELAY_MS = 100,
  parameter logic [7:0]  CONTRAST      = 8'h0F
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic cs,
  output logic sclk,
  output logic sdo,
  output logic dc,
  output logic res,
  output logic vdd,
  output logic vbat,
  output logic busy,
  output logic fin
);

  localparam int CYC_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MS_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [11:0]      VBAT_MS  = 12'(VBAT_DELAY_MS);

  // Table boundaries where the sequence leaves the byte stream for a rail/delay step
  localparam logic [3:0] STEP_RST  = 4'd0;
  localparam logic [3:0] STEP_VBAT = 4'd4;
  localparam logic [3:0] STEP_LAST = 4'd13;

  typedef enum logic [3:0] {
    IDLE, VDD_ON, RST_LO, RST_HI, CMD, VBAT_ON, DELAY, DONE,
    PD_CMD, PD_VBAT, PD_OFF
  } state_t;

  typedef enum logic [1:0] {SP_START, SP_SHIFT, SP_GAP} spi_t;

  state_t           state;
  state_t           ret_state;
  spi_t             spi_ph;
  logic [3:0]       step;
  logic [7:0]       shreg;
  logic [3:0]       half_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [11:0]      ms_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [7:0]       cur_byte;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = 8'hAE;
      4'd1:    cmd_byte = 8'h8D;
      4'd2:    cmd_byte = 8'h14;
      4'd3:    cmd_byte = 8'hD9;
      4'd4:    cmd_byte = 8'hF1;
      4'd5:    cmd_byte = 8'h81;
      4'd6:    cmd_byte = CONTRAST;
      4'd7:    cmd_byte = 8'hA0;
      4'd8:    cmd_byte = 8'hC0;
      4'd9:    cmd_byte = 8'hDA;
      4'd10:   cmd_byte = 8'h00;
      4'd11:   cmd_byte = 8'h20;
      4'd12:   cmd_byte = 8'h00;
      4'd13:   cmd_byte = 8'hAF;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign cur_byte = cmd_byte(step);

  // Commands only, never display data
  assign dc = 1'b0;

  // Sequencer FSM, SPI byte engine and ms delay counter, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
      spi_ph    <= SP_START;
      step      <= '0;
      shreg     <= '0;
      half_cnt  <= '0;
      div_cnt   <= '0;
      ms_cnt    <= '0;
      cyc_cnt   <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b1;
      sdo       <= 1'b0;
      res       <= 1'b0;
      vdd       <= 1'b1;
      vbat      <= 1'b1;
      busy      <= 1'b0;
      fin       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= VDD_ON;
          end
        end

        VDD_ON: begin
          vdd       <= 1'b0;
          res       <= 1'b1;
          step      <= STEP_RST;
          spi_ph    <= SP_START;
          ms_cnt    <= 12'd1;
          cyc_cnt   <= '0;
          ret_state <= CMD;
          state     <= DELAY;
        end

        RST_LO: begin
          res       <= 1'b0;
          ms_cnt    <= 12'd1;
          cyc_cnt   <= '0;
          ret_state <= RST_HI;
          state     <= DELAY;
        end

        RST_HI: begin
          res       <= 1'b1;
          ms_cnt    <= 12'd1;
          cyc_cnt   <= '0;
          ret_state <= CMD;
          state     <= DELAY;
        end

        VBAT_ON: begin
          vbat      <= 1'b0;
          ms_cnt    <= VBAT_MS;
          cyc_cnt   <= '0;
          ret_state <= CMD;
          state     <= DELAY;
        end

        DELAY: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (ms_cnt <= 12'd1) state <= ret_state;
            else                 ms_cnt <= ms_cnt - 12'd1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        CMD, PD_CMD: begin
          case (spi_ph)
            // cs and sclk fall together; bit 7 is set up a full phase before the first rise
            SP_START: begin
              cs       <= 1'b0;
              sclk     <= 1'b0;
              sdo      <= cur_byte[7];
              shreg    <= {cur_byte[6:0], 1'b0};
              half_cnt <= '0;
              div_cnt  <= '0;
              spi_ph   <= SP_SHIFT;
            end
            SP_SHIFT: begin
              if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (half_cnt == 4'd15) begin
                  cs     <= 1'b1;
                  spi_ph <= SP_GAP;
                end else begin
                  half_cnt <= half_cnt + 4'd1;
                  sclk     <= ~sclk;
                  // next bit goes out on the falling edge only
                  if (sclk) begin
                    sdo   <= shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                  end
                end
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
            SP_GAP: begin
              if (div_cnt == GAP_LAST) begin
                div_cnt <= '0;
                spi_ph  <= SP_START;
                step    <= step + 4'd1;
                if (state == PD_CMD) begin
                  state <= PD_VBAT;
                end else if (step == STEP_RST) begin
                  state <= RST_LO;
                end else if (step == STEP_VBAT) begin
                  state <= VBAT_ON;
                end else if (step == STEP_LAST) begin
                  busy  <= 1'b0;
                  fin   <= 1'b1;
                  state <= DONE;
                end
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
            default: spi_ph <= SP_START;
          endcase
        end

        DONE: begin
          if (stop) begin
            fin <= 1'b0;
`ifdef OLED_SEQ_PWRDOWN_EN
            busy   <= 1'b1;
            step   <= STEP_RST;
            spi_ph <= SP_START;
            state  <= PD_CMD;
`else
            state  <= IDLE;
`endif
          end
        end

        PD_VBAT: begin
          vbat      <= 1'b1;
          ms_cnt    <= VBAT_MS;
          cyc_cnt   <= '0;
          ret_state <= PD_OFF;
          state     <= DELAY;
        end

        PD_OFF: begin
          vdd   <= 1'b1;
          res   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_seq.sv
// tb/tb_oled_seq.sv - scoreboard bench for oled_seq
`timescale 1ns/1ps

module tb_oled_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cs, sclk, sdo, dc, res, vdd, vbat, busy, fin;
  logic cs2, sclk2, sdo2, dc2, res2, vdd2, vbat2, busy2, fin2;

  oled_seq #(.CLK_DIV(2), .MS_CYCLES(10), .VBAT_DELAY_MS(100)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cs(cs), .sclk(sclk), .sdo(sdo), .dc(dc), .res(res),
    .vdd(vdd), .vbat(vbat), .busy(busy), .fin(fin)
  );

  oled_seq #(.CLK_DIV(2), .MS_CYCLES(10), .VBAT_DELAY_MS(100), .CONTRAST(8'h7F)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cs(cs2), .sclk(sclk2), .sdo(sdo2), .dc(dc2), .res(res2),
    .vdd(vdd2), .vbat(vbat2), .busy(busy2), .fin(fin2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int byte_cnt = 0;
  int base = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] cap2_q[$];
  logic [7:0] seq_tbl[14] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
                              8'hA0, 8'hC0, 8'hDA, 8'h00, 8'h20, 8'h00, 8'hAF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_seq();
    foreach (seq_tbl[i]) exp_q.push_back(seq_tbl[i]);
  endtask

  // Monitor: captures bytes from the default DUT and scores them against exp_q
  logic [7:0] sh = 8'h00;
  int nb = 0, low_cnt = 0, res_lo = 0, since_vbat = 0;
  bit vbat_armed = 0;
  logic p_cs = 1'b1, p_sclk = 1'b1, p_sdo = 1'b0, p_vbat = 1'b1, p_res = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      nb = 0; low_cnt = 0; res_lo = 0; vbat_armed = 0;
      p_cs = 1'b1; p_sclk = 1'b1; p_sdo = 1'b0; p_vbat = 1'b1; p_res = 1'b0;
    end else begin
      if (cs === 1'b0) begin
        if (p_cs === 1'b1) begin
          low_cnt = 0;
          nb = 0;
          if (vbat_armed) begin
            chk("vbat_to_next_cs_fall", since_vbat >= 1000, since_vbat, 1000);
            vbat_armed = 0;
          end
        end
        low_cnt++;
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
          chk("sdo_stable_at_rise", sdo === p_sdo, sdo, p_sdo);
          chk("dc_low", dc === 1'b0, dc, 0);
          sh = {sh[6:0], sdo};
          nb++;
        end
      end else if (p_cs === 1'b0) begin
        chk("cs_low_cycles", low_cnt == 32, low_cnt, 32);
        chk("bits_per_byte", nb == 8, nb, 8);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 1'b0, sh, 0);
        end else begin
          e = exp_q.pop_front();
          chk("byte_value", sh === e, sh, e);
        end
        last_byte = sh;
        byte_cnt++;
      end
      if (vdd === 1'b0 && res === 1'b0) begin
        res_lo++;
      end else if (res === 1'b1 && p_res === 1'b0) begin
        if (res_lo > 0) chk("res_low_width", res_lo >= 10, res_lo, 10);
        res_lo = 0;
      end
      if (vbat === 1'b0 && p_vbat === 1'b1) begin
        chk("vbat_after_f1", last_byte == 8'hF1 && cs === 1'b1, last_byte, 8'hF1);
        vbat_armed = 1;
        since_vbat = 0;
      end
      if (vbat_armed) since_vbat++;
      p_cs = cs; p_sclk = sclk; p_sdo = sdo; p_vbat = vbat; p_res = res;
    end
  end

  // Capture of the CONTRAST=7F instance
  logic [7:0] sh2 = 8'h00;
  logic p_cs2 = 1'b1, p_sclk2 = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      p_cs2 = 1'b1; p_sclk2 = 1'b1;
    end else begin
      if (cs2 === 1'b0 && sclk2 === 1'b1 && p_sclk2 === 1'b0) sh2 = {sh2[6:0], sdo2};
      if (cs2 === 1'b1 && p_cs2 === 1'b0) cap2_q.push_back(sh2);
      p_cs2 = cs2; p_sclk2 = sclk2;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit p);
    @(posedge clk); #1;
    start = s; stop = p;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    for (int i = 0; i < budget && fin !== 1'b1; i++) tick(1);
    chk("fin_reached", fin === 1'b1, fin, 1);
  endtask

  task automatic do_stop();
`ifdef OLED_SEQ_PWRDOWN_EN
    begin
      int t_vb;
      t_vb = -1;
      exp_q.push_back(8'hAE);
      pulse(1'b0, 1'b1);
      chk("pd_fin_clear", fin === 1'b0, fin, 0);
      chk("pd_busy_set", busy === 1'b1, busy, 1);
      for (int i = 0; i < 5000 && busy === 1'b1; i++) begin
        tick(1);
        if (vbat === 1'b1 && t_vb < 0) t_vb = cyc;
      end
      chk("pd_busy_clear", busy === 1'b0, busy, 0);
      chk("pd_vdd_off", vdd === 1'b1, vdd, 1);
      chk("pd_vbat_off", vbat === 1'b1, vbat, 1);
      chk("pd_res_low", res === 1'b0, res, 0);
      chk("pd_vbat_to_vdd", t_vb >= 0 && (cyc - t_vb) >= 1000, cyc - t_vb, 1000);
      chk("pd_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    end
`else
    begin
      int b0;
      b0 = byte_cnt;
      pulse(1'b0, 1'b1);
      chk("stop_fin_clear", fin === 1'b0, fin, 0);
      chk("stop_busy_low", busy === 1'b0, busy, 0);
      tick(50);
      chk("stop_no_spi", byte_cnt == b0, byte_cnt, b0);
      chk("stop_cs_high", cs === 1'b1, cs, 1);
      chk("stop_vdd_kept", vdd === 1'b0, vdd, 0);
      chk("stop_vbat_kept", vbat === 1'b0, vbat, 0);
      chk("stop_res_kept", res === 1'b1, res, 1);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", cs === 1'b1, cs, 1);
    chk("rst_sclk", sclk === 1'b1, sclk, 1);
    chk("rst_sdo", sdo === 1'b0, sdo, 0);
    chk("rst_dc", dc === 1'b0, dc, 0);
    chk("rst_res", res === 1'b0, res, 0);
    chk("rst_vdd", vdd === 1'b1, vdd, 1);
    chk("rst_vbat", vbat === 1'b1, vbat, 1);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_fin", fin === 1'b0, fin, 0);
    rst = 1'b0;
    tick(2);

    // Full power-up sequence, plus contrast variant on the second instance
    cap2_q.delete();
    base = byte_cnt;
    push_seq();
    pulse(1'b1, 1'b0);
    chk("busy_after_start", busy === 1'b1, busy, 1);
    wait_fin(4000);
    chk("busy_low_in_done", busy === 1'b0, busy, 0);
    chk("seq_byte_count", byte_cnt - base == 14, byte_cnt - base, 14);
    chk("seq_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    chk("c7f_byte_count", cap2_q.size() == 14, cap2_q.size(), 14);
    for (int i = 0; i < 14 && i < cap2_q.size(); i++)
      chk($sformatf("c7f_byte%0d", i), cap2_q[i] === ((i == 6) ? 8'h7F : seq_tbl[i]),
          cap2_q[i], (i == 6) ? 8'h7F : seq_tbl[i]);

    do_stop();

    // Stray start/stop pulses while the sequence runs
    base = byte_cnt;
    push_seq();
    pulse(1'b1, 1'b0);
    tick(20);
    pulse(1'b1, 1'b0);
    chk("extra_start_fin", fin === 1'b0, fin, 0);
    tick(200);
    pulse(1'b0, 1'b1);
    chk("early_stop_fin", fin === 1'b0, fin, 0);
    chk("early_stop_busy", busy === 1'b1, busy, 1);
    tick(300);
    pulse(1'b1, 1'b1);
    chk("both_pulse_busy", busy === 1'b1, busy, 1);
    wait_fin(4000);
    chk("stray_byte_count", byte_cnt - base == 14, byte_cnt - base, 14);
    chk("stray_queue_empty", exp_q.size() == 0, exp_q.size(), 0);

    do_stop();

    // Reset in the middle of the third byte, then restart with start and stop together
    base = byte_cnt;
    push_seq();
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 2000 && !(byte_cnt - base == 2 && cs === 1'b0); i++) tick(1);
    chk("third_byte_started", byte_cnt - base == 2 && cs === 1'b0, byte_cnt - base, 2);
    tick(10);
    rst = 1'b1;
    #1;
    chk("abort_cs", cs === 1'b1, cs, 1);
    chk("abort_sclk", sclk === 1'b1, sclk, 1);
    chk("abort_vdd", vdd === 1'b1, vdd, 1);
    chk("abort_vbat", vbat === 1'b1, vbat, 1);
    chk("abort_busy", busy === 1'b0, busy, 0);
    exp_q.delete();
    tick(3);
    rst = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    base = byte_cnt;
    push_seq();
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    chk("start_first_edge", busy === 1'b1, busy, 1);
    wait_fin(4000);
    chk("restart_byte_count", byte_cnt - base == 14, byte_cnt - base, 14);
    chk("restart_queue_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
